// File: rtl/apb_master_arbiter.sv
// apb_master_arbiter
// Two-requester round-robin front end for a single APB master port.
// One transfer is in flight at a time: IDLE -> SETUP -> ACCESS -> IDLE.
// The APB request fields are captured on acceptance and held until the next
// acceptance. The response is a one-cycle pulse on the requester's rsp_valid
// bit. An optional ACCESS-phase watchdog forces an error response.
module apb_master_arbiter #(
    parameter int dataWidth = 32,
    parameter int addrWidth = 32,
    parameter int TIMEOUT   = 16
) (
    input  logic                       pclk,
    input  logic                       presetn,
    input  logic [1:0]                 req_valid,
    output logic [1:0]                 req_ready,
    input  logic [1:0]                 req_write,
    input  logic [2*addrWidth-1:0]     req_addr,
    input  logic [2*dataWidth-1:0]     req_wdata,
    input  logic [2*(dataWidth/8)-1:0] req_strb,
    input  logic [5:0]                 req_prot,
    output logic [1:0]                 rsp_valid,
    output logic [dataWidth-1:0]       rsp_rdata,
    output logic                       rsp_err,
    output logic [addrWidth-1:0]       paddr,
    output logic [2:0]                 pprot,
    output logic                       pwrite,
    output logic [dataWidth-1:0]       pwdata,
    output logic [dataWidth/8-1:0]     pstrb,
    output logic                       pselx,
    output logic                       penable,
    input  logic                       pready,
    input  logic [dataWidth-1:0]       prdata,
    input  logic                       pslverr
);

    localparam int STRB_W = dataWidth / 8;
    localparam int CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam bit TO_EN  = (TIMEOUT > 0);
    // Counter value seen during the last permitted waiting ACCESS cycle.
    localparam logic [CNT_W-1:0] TO_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_e;

    state_e             state_q;
    logic               idle_q;     // 1 only in IDLE once out of reset; gates req_ready
    logic               last_q;     // requester granted most recently
    logic               act_q;      // requester owning the current transfer
    logic [CNT_W-1:0]   cnt_q;
    logic [addrWidth-1:0] paddr_q;
    logic [2:0]         pprot_q;
    logic               pwrite_q;
    logic [dataWidth-1:0] pwdata_q;
    logic [STRB_W-1:0]  pstrb_q;
    logic               pselx_q;
    logic               penable_q;
    logic [1:0]         rsp_valid_q;
    logic [dataWidth-1:0] rsp_rdata_q;
    logic               rsp_err_q;

    logic               gnt_any_s;
    logic               gnt_idx_s;
    logic               timeout_hit_s;

    // Round-robin pick: on contention the requester not granted last wins.
    always_comb begin
        gnt_any_s = 1'b0;
        gnt_idx_s = 1'b0;
        case (req_valid)
            2'b01: begin
                gnt_any_s = 1'b1;
                gnt_idx_s = 1'b0;
            end
            2'b10: begin
                gnt_any_s = 1'b1;
                gnt_idx_s = 1'b1;
            end
            2'b11: begin
                gnt_any_s = 1'b1;
                gnt_idx_s = ~last_q;
            end
            default: begin
                gnt_any_s = 1'b0;
                gnt_idx_s = 1'b0;
            end
        endcase
    end

    // Accept pulse: only while idle, so it lasts exactly the acceptance cycle.
    always_comb begin
        req_ready = 2'b00;
        if (idle_q && gnt_any_s) begin
            req_ready = gnt_idx_s ? 2'b10 : 2'b01;
        end else begin
            req_ready = 2'b00;
        end
    end

    // Watchdog: the current waiting ACCESS cycle is the last one allowed.
    always_comb begin
        timeout_hit_s = 1'b0;
        if (TO_EN && (cnt_q == TO_LAST)) begin
            timeout_hit_s = 1'b1;
        end else begin
            timeout_hit_s = 1'b0;
        end
    end

    // Transfer FSM with all APB and response outputs registered.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q     <= ST_IDLE;
            idle_q      <= 1'b0;
            last_q      <= 1'b1;
            act_q       <= 1'b0;
            cnt_q       <= '0;
            paddr_q     <= '0;
            pprot_q     <= 3'b000;
            pwrite_q    <= 1'b0;
            pwdata_q    <= '0;
            pstrb_q     <= '0;
            pselx_q     <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 2'b00;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            rsp_valid_q <= 2'b00;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (idle_q && gnt_any_s) begin
                        state_q   <= ST_SETUP;
                        idle_q    <= 1'b0;
                        last_q    <= gnt_idx_s;
                        act_q     <= gnt_idx_s;
                        pselx_q   <= 1'b1;
                        penable_q <= 1'b0;
                        if (gnt_idx_s) begin
                            pwrite_q <= req_write[1];
                            paddr_q  <= req_addr[2*addrWidth-1:addrWidth];
                            pwdata_q <= req_wdata[2*dataWidth-1:dataWidth];
                            pstrb_q  <= req_strb[2*STRB_W-1:STRB_W];
                            pprot_q  <= req_prot[5:3];
                        end else begin
                            pwrite_q <= req_write[0];
                            paddr_q  <= req_addr[addrWidth-1:0];
                            pwdata_q <= req_wdata[dataWidth-1:0];
                            pstrb_q  <= req_strb[STRB_W-1:0];
                            pprot_q  <= req_prot[2:0];
                        end
                    end else begin
                        idle_q <= 1'b1;
                    end
                end
                ST_SETUP: begin
                    state_q   <= ST_ACCESS;
                    penable_q <= 1'b1;
                    cnt_q     <= '0;
                end
                ST_ACCESS: begin
                    if (pready) begin
                        state_q     <= ST_IDLE;
                        idle_q      <= 1'b1;
                        pselx_q     <= 1'b0;
                        penable_q   <= 1'b0;
                        rsp_valid_q <= act_q ? 2'b10 : 2'b01;
                        rsp_rdata_q <= pwrite_q ? '0 : prdata;
                        rsp_err_q   <= pslverr;
                    end else if (timeout_hit_s) begin
                        state_q     <= ST_IDLE;
                        idle_q      <= 1'b1;
                        pselx_q     <= 1'b0;
                        penable_q   <= 1'b0;
                        cnt_q       <= cnt_q + CNT_W'(1);
                        rsp_valid_q <= act_q ? 2'b10 : 2'b01;
                        rsp_rdata_q <= '0;
                        rsp_err_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    idle_q    <= 1'b1;
                    pselx_q   <= 1'b0;
                    penable_q <= 1'b0;
                end
            endcase
        end
    end

    assign paddr     = paddr_q;
    assign pprot     = pprot_q;
    assign pwrite    = pwrite_q;
    assign pwdata    = pwdata_q;
    assign pstrb     = pstrb_q;
    assign pselx     = pselx_q;
    assign penable   = penable_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Self-checking bench for apb_master_arbiter: table of single transfers,
// round-robin contention, and reset during ACCESS. Responses are checked
// against a queue of expected results filled when requests are driven.
module tb_apb_master_arbiter;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int SW = DW / 8;
    localparam int TO = 16;

    logic            pclk = 1'b0;
    logic            presetn = 1'b1;
    logic [1:0]      req_valid = 2'b00;
    logic [1:0]      req_ready;
    logic [1:0]      req_write = 2'b00;
    logic [2*AW-1:0] req_addr = '0;
    logic [2*DW-1:0] req_wdata = '0;
    logic [2*SW-1:0] req_strb = '0;
    logic [5:0]      req_prot = 6'd0;
    logic [1:0]      rsp_valid;
    logic [DW-1:0]   rsp_rdata;
    logic            rsp_err;
    logic [AW-1:0]   paddr;
    logic [2:0]      pprot;
    logic            pwrite;
    logic [DW-1:0]   pwdata;
    logic [SW-1:0]   pstrb;
    logic            pselx;
    logic            penable;
    logic            pready = 1'b0;
    logic [DW-1:0]   prdata = '0;
    logic            pslverr = 1'b0;

    apb_master_arbiter #(.dataWidth(DW), .addrWidth(AW), .TIMEOUT(TO)) dut (
        .pclk(pclk), .presetn(presetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb),
        .req_prot(req_prot),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .paddr(paddr), .pprot(pprot), .pwrite(pwrite), .pwdata(pwdata),
        .pstrb(pstrb), .pselx(pselx), .penable(penable),
        .pready(pready), .prdata(prdata), .pslverr(pslverr)
    );

    always #5 pclk = ~pclk;

    typedef struct {
        logic        req;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [2:0]  prot;
        int          waits;
        logic        err;
        logic [31:0] rdata;
        int          exp_acc;
        logic [1:0]  exp_rv;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [1:0]  rv;
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    rsp_t exp_q[$];
    rsp_t mon_e;
    int   n_checks = 0;
    int   n_pass = 0;

    // completer configuration
    int          wait_cfg = 0;
    int          wcnt = 0;
    logic        err_cfg = 1'b0;
    logic [31:0] rdata_cfg = 32'h0;
    logic        mode_addr = 1'b0;

    task automatic chk(input string name, input bit ok, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    endtask

    // APB completer: pready after wait_cfg waiting ACCESS cycles
    always @(negedge pclk) begin
        if (pselx === 1'b1 && penable === 1'b1) begin
            pready = (wcnt >= wait_cfg);
            wcnt = wcnt + 1;
        end else begin
            pready = 1'b0;
            wcnt = 0;
        end
        pslverr = pready & err_cfg;
        prdata = mode_addr ? {16'hC0DE, paddr[15:0]} : rdata_cfg;
    end

    // response monitor / scoreboard
    always @(negedge pclk) begin
        if (rsp_valid !== 2'b00) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_rsp", 1'b0, 64'(rsp_valid), 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("rsp", (rsp_valid === mon_e.rv) && (rsp_rdata === mon_e.rdata) && (rsp_err === mon_e.err),
                    64'({rsp_valid, rsp_err, rsp_rdata}), 64'({mon_e.rv, mon_e.err, mon_e.rdata}));
            end
            chk("rsp_onehot_no_setup", ($countones(rsp_valid) == 1) && !(pselx === 1'b1 && penable === 1'b0),
                64'({pselx, penable, rsp_valid}), 64'(rsp_valid));
        end
    end

    task automatic chk_zero(input string tag);
        chk({tag, "_ctl"}, (pselx === 1'b0) && (penable === 1'b0) && (pwrite === 1'b0) && (req_ready === 2'b00)
            && (rsp_valid === 2'b00) && (rsp_err === 1'b0),
            64'({pselx, penable, pwrite, req_ready, rsp_valid, rsp_err}), 64'd0);
        chk({tag, "_data"}, (paddr === 32'h0) && (pwdata === 32'h0) && (pstrb === 4'h0) && (pprot === 3'b000)
            && (rsp_rdata === 32'h0), 64'({paddr, pwdata}), 64'd0);
    endtask

    task automatic wait_accept(output int t);
        for (t = 0; t < 20; t++) begin
            @(negedge pclk);
            if (req_ready !== 2'b00) break;
        end
    endtask

    task automatic drain(input string tag);
        int t;
        for (t = 0; t < 60; t++) begin
            if (exp_q.size() == 0) break;
            @(negedge pclk);
        end
        chk(tag, exp_q.size() == 0, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic do_txn(input vec_t v);
        int   i;
        int   t;
        int   n;
        bit   stable;
        rsp_t r;
        i = int'(v.req);
        stable = 1'b1;
        @(posedge pclk); #1;
        req_write[i] = v.wr;
        req_addr[i*AW +: AW] = v.addr;
        req_wdata[i*DW +: DW] = v.wdata;
        req_strb[i*SW +: SW] = v.strb;
        req_prot[i*3 +: 3] = v.prot;
        req_valid[i] = 1'b1;
        wait_cfg = v.waits;
        err_cfg = v.err;
        rdata_cfg = v.rdata;
        mode_addr = 1'b0;
        r.rv = v.exp_rv;
        r.rdata = v.exp_rdata;
        r.err = v.exp_err;
        exp_q.push_back(r);
        wait_accept(t);
        chk("accept", (t < 20) && (req_ready === (v.req ? 2'b10 : 2'b01)),
            64'(req_ready), 64'(v.req ? 2'b10 : 2'b01));
        @(posedge pclk); #1;
        req_valid[i] = 1'b0;
        @(negedge pclk);
        chk("setup", (pselx === 1'b1) && (penable === 1'b0) && (req_ready === 2'b00) && (paddr === v.addr)
            && (pwrite === v.wr) && (pwdata === v.wdata) && (pstrb === v.strb) && (pprot === v.prot),
            64'({pselx, penable, paddr}), 64'({2'b10, v.addr}));
        n = 0;
        for (t = 0; t < 60; t++) begin
            @(negedge pclk);
            if (pselx === 1'b1 && penable === 1'b1) begin
                n++;
                if (!((paddr === v.addr) && (pwrite === v.wr) && (pwdata === v.wdata) && (pstrb === v.strb)
                      && (pprot === v.prot) && (req_ready === 2'b00))) stable = 1'b0;
            end else begin
                break;
            end
        end
        chk("access_stable", stable, 64'(stable), 64'd1);
        chk("access_cycles", n == v.exp_acc, 64'(n), 64'(v.exp_acc));
        chk("complete", (pselx === 1'b0) && (penable === 1'b0) && (rsp_valid === v.exp_rv),
            64'({pselx, penable, rsp_valid}), 64'(v.exp_rv));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[6];
        vec_t vf;
        int   t;
        rsp_t r;

        vt[0] = '{req:1'b0, wr:1'b0, addr:32'h0000_0010, wdata:32'h0, strb:4'h0, prot:3'b000, waits:0,
                  err:1'b0, rdata:32'hDEAD_BEEF, exp_acc:1, exp_rv:2'b01, exp_rdata:32'hDEAD_BEEF, exp_err:1'b0};
        vt[1] = '{req:1'b1, wr:1'b1, addr:32'h2000_0040, wdata:32'h1234_5678, strb:4'hF, prot:3'b010, waits:3,
                  err:1'b1, rdata:32'hAAAA_5555, exp_acc:4, exp_rv:2'b10, exp_rdata:32'h0, exp_err:1'b1};
        vt[2] = '{req:1'b1, wr:1'b0, addr:32'h0000_0F04, wdata:32'h0, strb:4'h0, prot:3'b101, waits:1,
                  err:1'b0, rdata:32'hCAFE_F00D, exp_acc:2, exp_rv:2'b10, exp_rdata:32'hCAFE_F00D, exp_err:1'b0};
        vt[3] = '{req:1'b0, wr:1'b1, addr:32'h8000_0000, wdata:32'hA5A5_A5A5, strb:4'b0101, prot:3'b111, waits:0,
                  err:1'b0, rdata:32'hFFFF_FFFF, exp_acc:1, exp_rv:2'b01, exp_rdata:32'h0, exp_err:1'b0};
        vt[4] = '{req:1'b0, wr:1'b0, addr:32'hFFFF_FFFC, wdata:32'h0, strb:4'h0, prot:3'b001, waits:2,
                  err:1'b1, rdata:32'h0BAD_F00D, exp_acc:3, exp_rv:2'b01, exp_rdata:32'h0BAD_F00D, exp_err:1'b1};
        vt[5] = '{req:1'b1, wr:1'b0, addr:32'h0000_1000, wdata:32'h0, strb:4'h0, prot:3'b000, waits:40,
                  err:1'b0, rdata:32'h1111_2222, exp_acc:16, exp_rv:2'b10, exp_rdata:32'h0, exp_err:1'b1};
        vf    = '{req:1'b1, wr:1'b0, addr:32'h0000_0044, wdata:32'h0, strb:4'h0, prot:3'b011, waits:0,
                  err:1'b0, rdata:32'h55AA_55AA, exp_acc:1, exp_rv:2'b10, exp_rdata:32'h55AA_55AA, exp_err:1'b0};

        // reset state, with requests pending to prove req_ready is held low
        #1 presetn = 1'b0;
        req_valid = 2'b11;
        repeat (3) @(negedge pclk);
        chk_zero("reset");
        req_valid = 2'b00;
        @(negedge pclk);
        presetn = 1'b1;

        // round-robin contention right after reset: 0,1,0,1
        @(posedge pclk); #1;
        req_addr = {32'h0000_0200, 32'h0000_0100};
        req_write = 2'b00;
        req_prot = 6'd0;
        mode_addr = 1'b1;
        wait_cfg = 0;
        err_cfg = 1'b0;
        req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            r.rv = (k % 2 == 0) ? 2'b01 : 2'b10;
            r.rdata = (k % 2 == 0) ? 32'hC0DE_0100 : 32'hC0DE_0200;
            r.err = 1'b0;
            exp_q.push_back(r);
        end
        for (int k = 0; k < 4; k++) begin
            wait_accept(t);
            chk("rr_grant", (t < 20) && (req_ready === ((k % 2 == 0) ? 2'b01 : 2'b10)),
                64'(req_ready), 64'((k % 2 == 0) ? 2'b01 : 2'b10));
            if (k == 3) begin
                @(posedge pclk); #1;
                req_valid = 2'b00;
            end
            @(negedge pclk);
            chk("rr_ready_width", req_ready === 2'b00, 64'(req_ready), 64'd0);
        end
        drain("rr_drain");

        // table of single transfers
        for (int v = 0; v < 6; v++) begin
            do_txn(vt[v]);
        end
        drain("table_drain");

        // reset in the middle of ACCESS: no response may appear
        @(posedge pclk); #1;
        req_addr[AW-1:0] = 32'h0000_0300;
        req_write[0] = 1'b0;
        wait_cfg = 100;
        mode_addr = 1'b0;
        req_valid = 2'b01;
        wait_accept(t);
        chk("mid_accept", (t < 20) && (req_ready === 2'b01), 64'(req_ready), 64'h1);
        @(posedge pclk); #1;
        req_valid = 2'b00;
        for (t = 0; t < 10; t++) begin
            @(negedge pclk);
            if (penable === 1'b1) break;
        end
        chk("mid_reach_access", t < 10, 64'(t), 64'd0);
        repeat (3) @(negedge pclk);
        #2 presetn = 1'b0;
        #1 chk_zero("async_reset");
        repeat (2) @(negedge pclk);
        chk_zero("held_reset");
        presetn = 1'b1;
        repeat (3) @(negedge pclk);
        do_txn(vf);
        drain("post_reset_drain");

        chk("queue_empty", exp_q.size() == 0, 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
